// File: rtl/ifq_pair_if.sv
// Fetch-to-decode bundle for the pairing queue: the fetch packet side and the
// two-wide decode presentation side.
interface ifq_pair_if;
  logic [63:0] f_pc;
  logic [63:0] f_data;
  logic [1:0]  f_slot_valid;
  logic [1:0]  f_bp;
  logic [3:0]  f_bp_track;
  logic [63:0] f_bt;
  logic        f_valid;
  logic        f_ready;

  logic [63:0] if_dec0_pc;
  logic [31:0] if_dec0_instr;
  logic        if_dec0_bp;
  logic [1:0]  if_dec0_bp_track;
  logic [63:0] if_dec0_bt;
  logic        if_dec0_valid;
  logic [63:0] if_dec1_pc;
  logic [31:0] if_dec1_instr;
  logic        if_dec1_bp;
  logic [1:0]  if_dec1_bp_track;
  logic [63:0] if_dec1_bt;
  logic        if_dec1_valid;
  logic        if_dec_ready;

  modport master (
    output f_pc, f_data, f_slot_valid, f_bp, f_bp_track, f_bt, f_valid,
    input  f_ready,
    input  if_dec0_pc, if_dec0_instr, if_dec0_bp, if_dec0_bp_track, if_dec0_bt, if_dec0_valid,
    input  if_dec1_pc, if_dec1_instr, if_dec1_bp, if_dec1_bp_track, if_dec1_bt, if_dec1_valid,
    output if_dec_ready
  );

  modport slave (
    input  f_pc, f_data, f_slot_valid, f_bp, f_bp_track, f_bt, f_valid,
    output f_ready,
    output if_dec0_pc, if_dec0_instr, if_dec0_bp, if_dec0_bp_track, if_dec0_bt, if_dec0_valid,
    output if_dec1_pc, if_dec1_instr, if_dec1_bp, if_dec1_bp_track, if_dec1_bt, if_dec1_valid,
    input  if_dec_ready
  );
endinterface

// File: rtl/ifq_pair.sv
// Fetch-side pairing queue: compacts valid slots of 2-wide fetch packets into an
// in-order FIFO and presents the two oldest instructions to decode.
module ifq_pair #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ABITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pipe_flush,
  ifq_pair_if.slave  fq
);
  localparam int unsigned CW = ABITS + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        bp;
    logic [1:0]  bp_track;
    logic [63:0] bt;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [ABITS-1:0] rp_q, rp_d, wp_q, wp_d, rp1;
  logic [CW-1:0]    count_q, count_d, npush, npop;
  logic             dec0_valid_q, dec0_valid_d;
  logic             dec1_valid_q, dec1_valid_d;
  logic             f_ready_q, f_ready_d;
  logic             s0_v, s1_v, push_en;
  entry_t           e0, e1;

  // Slot decode, compaction write and pointer/count bookkeeping.
  always_comb begin
    s0_v    = fq.f_slot_valid[0];
    s1_v    = fq.f_slot_valid[1] && !(fq.f_slot_valid[0] && fq.f_bp[0]);
    push_en = fq.f_valid && f_ready_q && !pipe_flush && !rst;

    e0 = '{pc: {fq.f_pc[63:3], 3'b000}, instr: fq.f_data[31:0], bp: fq.f_bp[0],
           bp_track: fq.f_bp_track[1:0], bt: fq.f_bt};
    e1 = '{pc: {fq.f_pc[63:3], 3'b100}, instr: fq.f_data[63:32], bp: fq.f_bp[1],
           bp_track: fq.f_bp_track[3:2], bt: fq.f_bt};

    npush = push_en ? (CW'(s0_v) + CW'(s1_v)) : '0;
    npop  = fq.if_dec_ready ? (CW'(dec0_valid_q) + CW'(dec1_valid_q)) : '0;

    mem_d = mem_q;
    if (push_en) begin
      if (s0_v) begin
        mem_d[wp_q] = e0;
        if (s1_v) mem_d[wp_q + ABITS'(1)] = e1;
      end else if (s1_v) begin
        mem_d[wp_q] = e1;
      end
    end

    rp_d    = rp_q + ABITS'(npop);
    wp_d    = wp_q + ABITS'(npush);
    count_d = count_q + npush - npop;
    if (pipe_flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end

    dec0_valid_d = count_d >= CW'(1);
    dec1_valid_d = count_d >= CW'(2);
    f_ready_d    = (CW'(DEPTH) - count_d) >= CW'(2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q         <= '0;
      wp_q         <= '0;
      count_q      <= '0;
      dec0_valid_q <= 1'b0;
      dec1_valid_q <= 1'b0;
      f_ready_q    <= 1'b1;
    end else begin
      rp_q         <= rp_d;
      wp_q         <= wp_d;
      count_q      <= count_d;
      dec0_valid_q <= dec0_valid_d;
      dec1_valid_q <= dec1_valid_d;
      f_ready_q    <= f_ready_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rp1 = rp_q + ABITS'(1);

  assign fq.f_ready          = f_ready_q;
  assign fq.if_dec0_valid    = dec0_valid_q;
  assign fq.if_dec1_valid    = dec1_valid_q;
  assign fq.if_dec0_pc       = mem_q[rp_q].pc;
  assign fq.if_dec0_instr    = mem_q[rp_q].instr;
  assign fq.if_dec0_bp       = mem_q[rp_q].bp;
  assign fq.if_dec0_bp_track = mem_q[rp_q].bp_track;
  assign fq.if_dec0_bt       = mem_q[rp_q].bt;
  assign fq.if_dec1_pc       = mem_q[rp1].pc;
  assign fq.if_dec1_instr    = mem_q[rp1].instr;
  assign fq.if_dec1_bp       = mem_q[rp1].bp;
  assign fq.if_dec1_bp_track = mem_q[rp1].bp_track;
  assign fq.if_dec1_bt       = mem_q[rp1].bt;
endmodule

// File: tb/tb_ifq_pair.sv
// Bench for ifq_pair: directed vector table plus randomized traffic against a
// queue-based reference model.
module tb_ifq_pair;
  localparam int unsigned DEPTH = 4;

  logic clk, rst, pipe_flush;
  ifq_pair_if fq ();

  ifq_pair #(.DEPTH(DEPTH), .ABITS(2)) dut (
    .clk(clk), .rst(rst), .pipe_flush(pipe_flush), .fq(fq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        bp;
    logic [1:0]  trk;
    logic [63:0] bt;
  } m_ent_t;

  typedef struct {
    logic        rst, fl, fv;
    logic [63:0] pc, data;
    logic [1:0]  sv, bp;
    logic [3:0]  trk;
    logic [63:0] bt;
    logic        rdy;
    logic        ev0, ev1, efr;
    logic [63:0] epc0;
    logic [31:0] ein0;
    logic        ebp0;
    logic [1:0]  etrk0;
    logic [63:0] ebt0, epc1;
    logic [31:0] ein1;
  } vec_t;

  m_ent_t mq[$];
  vec_t   tv[$];
  int     total = 0;
  int     bad = 0;

  function automatic logic [63:0] mkd(input logic [63:0] pc);
    logic [31:0] lo, hi;
    lo = pc[31:0];
    hi = lo + 32'd4;
    return {hi, lo};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: the queue is the FIFO contents; size() is the occupancy.
  task automatic model_edge();
    int unsigned n;
    logic fr, s0, s1;
    n  = mq.size();
    fr = (DEPTH - n) >= 2;
    if (rst || pipe_flush) begin
      mq.delete();
      return;
    end
    if (fq.if_dec_ready) repeat ((n > 2) ? 2 : n) void'(mq.pop_front());
    if (fq.f_valid && fr) begin
      s0 = fq.f_slot_valid[0];
      s1 = fq.f_slot_valid[1] && !(fq.f_slot_valid[0] && fq.f_bp[0]);
      if (s0) mq.push_back('{{fq.f_pc[63:3], 3'b000}, fq.f_data[31:0], fq.f_bp[0], fq.f_bp_track[1:0], fq.f_bt});
      if (s1) mq.push_back('{{fq.f_pc[63:3], 3'b100}, fq.f_data[63:32], fq.f_bp[1], fq.f_bp_track[3:2], fq.f_bt});
    end
  endtask

  task automatic model_check();
    chk("m_v0", 64'(fq.if_dec0_valid), 64'(mq.size() >= 1));
    chk("m_v1", 64'(fq.if_dec1_valid), 64'(mq.size() >= 2));
    chk("m_fready", 64'(fq.f_ready), 64'((DEPTH - mq.size()) >= 2));
    if (mq.size() >= 1) begin
      chk("m_pc0", fq.if_dec0_pc, mq[0].pc);
      chk("m_in0", 64'(fq.if_dec0_instr), 64'(mq[0].instr));
      chk("m_bp0", 64'(fq.if_dec0_bp), 64'(mq[0].bp));
      chk("m_trk0", 64'(fq.if_dec0_bp_track), 64'(mq[0].trk));
      if (mq[0].bp) chk("m_bt0", fq.if_dec0_bt, mq[0].bt);
    end
    if (mq.size() >= 2) begin
      chk("m_pc1", fq.if_dec1_pc, mq[1].pc);
      chk("m_in1", 64'(fq.if_dec1_instr), 64'(mq[1].instr));
      chk("m_bp1", 64'(fq.if_dec1_bp), 64'(mq[1].bp));
      chk("m_trk1", 64'(fq.if_dec1_bp_track), 64'(mq[1].trk));
      if (mq[1].bp) chk("m_bt1", fq.if_dec1_bt, mq[1].bt);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    pipe_flush      = v.fl;
    fq.f_valid      = v.fv;
    fq.f_pc         = v.pc;
    fq.f_data       = v.data;
    fq.f_slot_valid = v.sv;
    fq.f_bp         = v.bp;
    fq.f_bp_track   = v.trk;
    fq.f_bt         = v.bt;
    fq.if_dec_ready = v.rdy;
  endtask

  initial begin
    clk = 1'b0;
    drive('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    // rst fl fv pc data sv bp trk bt rdy | ev0 ev1 efr epc0 ein0 ebp0 etrk0 ebt0 epc1 ein1
    tv.push_back('{1,0,0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h1000,64'h00B50533_00A00513,2'b11,0,0,0,0, 1,1,1,64'h1000,32'h00A00513,0,0,0,64'h1004,32'h00B50533});
    tv.push_back('{0,0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h2004,64'hAAAA0001_BBBB0000,2'b10,0,0,0,0, 1,0,1,64'h2004,32'hAAAA0001,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h2008,64'h22222222_11111111,2'b11,0,0,0,1, 1,1,1,64'h2008,32'h11111111,0,0,0,64'h200C,32'h22222222});
    tv.push_back('{0,0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h4003,64'hDEADBEEF_12345678,2'b11,2'b01,4'b0011,64'h3000,0, 1,0,1,64'h4000,32'h12345678,1,2'b11,64'h3000,0,0});
    tv.push_back('{0,0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h5000,mkd(64'h5000),2'b11,0,0,0,0, 1,1,1,64'h5000,32'h5000,0,0,0,64'h5004,32'h5004});
    tv.push_back('{0,0,1,64'h5008,mkd(64'h5008),2'b11,0,0,0,0, 1,1,0,64'h5000,32'h5000,0,0,0,64'h5004,32'h5004});
    tv.push_back('{0,0,1,64'h5010,mkd(64'h5010),2'b11,0,0,0,0, 1,1,0,64'h5000,32'h5000,0,0,0,64'h5004,32'h5004});
    tv.push_back('{0,0,1,64'h5010,mkd(64'h5010),2'b11,0,0,0,1, 1,1,1,64'h5008,32'h5008,0,0,0,64'h500C,32'h500C});
    tv.push_back('{0,0,1,64'h5010,mkd(64'h5010),2'b11,0,0,0,1, 1,1,1,64'h5010,32'h5010,0,0,0,64'h5014,32'h5014});
    tv.push_back('{0,0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h6000,mkd(64'h6000),2'b11,0,0,0,0, 1,1,1,64'h6000,32'h6000,0,0,0,64'h6004,32'h6004});
    tv.push_back('{0,0,1,64'h6008,mkd(64'h6008),2'b01,0,0,0,0, 1,1,0,64'h6000,32'h6000,0,0,0,64'h6004,32'h6004});
    tv.push_back('{0,0,1,64'h7000,mkd(64'h7000),2'b11,0,0,0,1, 1,0,1,64'h6008,32'h6008,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h7000,mkd(64'h7000),2'b11,0,0,0,1, 1,1,1,64'h7000,32'h7000,0,0,0,64'h7004,32'h7004});
    tv.push_back('{0,0,1,64'h8000,mkd(64'h8000),2'b01,0,0,0,0, 1,1,0,64'h7000,32'h7000,0,0,0,64'h7004,32'h7004});
    tv.push_back('{0,1,1,64'h9000,mkd(64'h9000),2'b11,0,0,0,1, 0,0,1,0,0,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h8100,mkd(64'h8100),2'b01,0,0,0,0, 1,0,1,64'h8100,32'h8100,0,0,0,0,0});
    tv.push_back('{0,0,1,64'h8200,mkd(64'h8200),2'b11,0,0,0,0, 1,1,0,64'h8100,32'h8100,0,0,0,64'h8200,32'h8200});
    tv.push_back('{1,0,1,64'hA000,mkd(64'hA000),2'b11,0,0,0,1, 0,0,1,0,0,0,0,0,0,0});
    tv.push_back('{0,0,0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0,0,0});

    foreach (tv[i]) begin
      drive(tv[i]);
      cyc();
      chk($sformatf("t%0d_v0", i), 64'(fq.if_dec0_valid), 64'(tv[i].ev0));
      chk($sformatf("t%0d_v1", i), 64'(fq.if_dec1_valid), 64'(tv[i].ev1));
      chk($sformatf("t%0d_fready", i), 64'(fq.f_ready), 64'(tv[i].efr));
      if (tv[i].ev0) begin
        chk($sformatf("t%0d_pc0", i), fq.if_dec0_pc, tv[i].epc0);
        chk($sformatf("t%0d_in0", i), 64'(fq.if_dec0_instr), 64'(tv[i].ein0));
        chk($sformatf("t%0d_bp0", i), 64'(fq.if_dec0_bp), 64'(tv[i].ebp0));
        chk($sformatf("t%0d_trk0", i), 64'(fq.if_dec0_bp_track), 64'(tv[i].etrk0));
        if (tv[i].ebp0) chk($sformatf("t%0d_bt0", i), fq.if_dec0_bt, tv[i].ebt0);
      end
      if (tv[i].ev1) begin
        chk($sformatf("t%0d_pc1", i), fq.if_dec1_pc, tv[i].epc1);
        chk($sformatf("t%0d_in1", i), 64'(fq.if_dec1_instr), 64'(tv[i].ein1));
      end
    end

    // Randomized traffic, checked cycle by cycle against the queue model.
    for (int k = 0; k < 600; k++) begin
      rst             = ($urandom_range(0, 63) == 0);
      pipe_flush      = ($urandom_range(0, 15) == 0);
      fq.f_valid      = ($urandom_range(0, 3) != 0);
      fq.f_pc         = {$urandom, $urandom};
      fq.f_data       = {$urandom, $urandom};
      fq.f_slot_valid = 2'($urandom_range(0, 3));
      fq.f_bp         = 2'($urandom_range(0, 3));
      fq.f_bp_track   = 4'($urandom_range(0, 15));
      fq.f_bt         = {$urandom, $urandom};
      fq.if_dec_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
